// File: rtl/first_edge_rd_arbiter.sv
// Round-robin share of one first-edge ROM read port among REQ_NUM credit-limited requesters.
// Latency: grant in cycle N -> bram_en/bram_addr in N+1 -> rsp_valid/rsp_data in N+RD_LATENCY+1.
// Backpressure: req_ready withheld while a requester has no credits; responses are never stalled.

`ifndef FIRST_EDGE_BRAM_AWIDTH
`define FIRST_EDGE_BRAM_AWIDTH 10
`endif
`ifndef FIRST_EDGE_BRAM_DWIDTH
`define FIRST_EDGE_BRAM_DWIDTH 32
`endif

module first_edge_rd_arbiter #(
   parameter int REQ_NUM    = 4,
   parameter int AWIDTH     = `FIRST_EDGE_BRAM_AWIDTH,
   parameter int DWIDTH     = `FIRST_EDGE_BRAM_DWIDTH,
   parameter int RD_LATENCY = 2,
   parameter int CREDIT_MAX = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [REQ_NUM-1:0]        req_valid,
   input  logic [REQ_NUM*AWIDTH-1:0] req_addr,
   output logic [REQ_NUM-1:0]        req_ready,
   output logic                      bram_en,
   output logic [AWIDTH-1:0]         bram_addr,
   input  logic [DWIDTH-1:0]         bram_data,
   output logic [REQ_NUM-1:0]        rsp_valid,
   output logic [DWIDTH-1:0]         rsp_data,
   input  logic [REQ_NUM-1:0]        credit_return,
   output logic                      busy,
   output logic                      credit_err
);

   localparam int IDW  = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
   localparam int CW   = $clog2(CREDIT_MAX + 1);
   localparam int NSTG = RD_LATENCY + 1;
   localparam logic [CW-1:0] CREDIT_FULL = CW'(CREDIT_MAX);

   // One slot of the tag pipeline that follows a read through the ROM.
   typedef struct packed {
      logic           vld;
      logic [IDW-1:0] id;
   } tag_t;

   logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]     credits_q [REQ_NUM];
   logic [CW-1:0]     credits_d [REQ_NUM];
   tag_t              tag_q [NSTG];
   tag_t              tag_d [NSTG];
   logic              bram_en_q, bram_en_d;
   logic [AWIDTH-1:0] bram_addr_q, bram_addr_d;
   logic              credit_err_q, credit_err_d;

   logic [REQ_NUM-1:0] eligible;
   logic               grant_vld;
   logic [IDW-1:0]     grant_idx;
   logic [AWIDTH-1:0]  grant_addr;

   // A requester may compete only while it has a downstream slot and reset is released.
   always_comb begin
      eligible = '0;
      for (int i = 0; i < REQ_NUM; i++) begin
         eligible[i] = rst && req_valid[i] && (credits_q[i] != '0);
      end
   end

   // Pick the first eligible requester at or after the round-robin pointer, wrapping.
   always_comb begin
      int idx;
      grant_vld = 1'b0;
      grant_idx = '0;
      idx       = 0;
      for (int k = 0; k < REQ_NUM; k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= REQ_NUM) begin
            idx = idx - REQ_NUM;
         end
         if (!grant_vld && eligible[IDW'(idx)]) begin
            grant_vld = 1'b1;
            grant_idx = IDW'(idx);
         end
      end
   end

   // Decode the winner into the one-hot ready and select its address.
   always_comb begin
      req_ready  = '0;
      grant_addr = '0;
      for (int i = 0; i < REQ_NUM; i++) begin
         if (grant_vld && (grant_idx == IDW'(i))) begin
            req_ready[i] = 1'b1;
            grant_addr   = req_addr[i*AWIDTH +: AWIDTH];
         end
      end
   end

   // Next-state: pointer advance, ROM issue, credit accounting and tag shift.
   always_comb begin
      rr_ptr_d     = rr_ptr_q;
      bram_en_d    = grant_vld;
      bram_addr_d  = grant_vld ? grant_addr : bram_addr_q;
      credit_err_d = credit_err_q;
      credits_d    = credits_q;

      if (grant_vld) begin
         rr_ptr_d = (int'(grant_idx) == REQ_NUM - 1) ? '0 : grant_idx + IDW'(1);
      end

      // A grant and a return in the same cycle cancel out; a return into a
      // full counter is a downstream accounting bug and is flagged, not applied.
      for (int i = 0; i < REQ_NUM; i++) begin
         if (req_ready[i] && !credit_return[i]) begin
            credits_d[i] = credits_q[i] - CW'(1);
         end else if (!req_ready[i] && credit_return[i]) begin
            if (credits_q[i] == CREDIT_FULL) begin
               credit_err_d = 1'b1;
            end else begin
               credits_d[i] = credits_q[i] + CW'(1);
            end
         end
      end

      tag_d[0].vld = grant_vld;
      tag_d[0].id  = grant_idx;
      for (int s = 1; s < NSTG; s++) begin
         tag_d[s] = tag_q[s-1];
      end
   end

   // State registers; reset drops in-flight reads and restores full credit.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rr_ptr_q     <= '0;
         bram_en_q    <= 1'b0;
         bram_addr_q  <= '0;
         credit_err_q <= 1'b0;
         for (int i = 0; i < REQ_NUM; i++) begin
            credits_q[i] <= CREDIT_FULL;
         end
         for (int s = 0; s < NSTG; s++) begin
            tag_q[s] <= '0;
         end
      end else begin
         rr_ptr_q     <= rr_ptr_d;
         bram_en_q    <= bram_en_d;
         bram_addr_q  <= bram_addr_d;
         credit_err_q <= credit_err_d;
         credits_q    <= credits_d;
         tag_q        <= tag_d;
      end
   end

   // Route the ROM output to the owner of the read that is completing now.
   always_comb begin
      rsp_valid = '0;
      busy      = 1'b0;
      for (int i = 0; i < REQ_NUM; i++) begin
         rsp_valid[i] = rst && tag_q[NSTG-1].vld && (tag_q[NSTG-1].id == IDW'(i));
      end
      for (int s = 0; s < NSTG; s++) begin
         busy = busy | tag_q[s].vld;
      end
   end

   assign rsp_data   = bram_data;
   assign bram_en    = bram_en_q;
   assign bram_addr  = bram_addr_q;
   assign credit_err = credit_err_q;

endmodule

// File: tb/tb_first_edge_rd_arbiter.sv
// Bench for first_edge_rd_arbiter: directed vector table, credit-exhaustion sequence,
// then randomized traffic against a queue-based reference model.
// The ROM is modelled here with two register stages behind bram_addr.

module tb_first_edge_rd_arbiter;

   localparam int N  = 4;
   localparam int AW = 10;
   localparam int DW = 32;
   localparam int CM = 8;
   localparam int LAT = 3;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N*AW-1:0] req_addr;
   logic [N-1:0]    req_ready;
   logic            bram_en;
   logic [AW-1:0]   bram_addr;
   logic [DW-1:0]   bram_data;
   logic [N-1:0]    rsp_valid;
   logic [DW-1:0]   rsp_data;
   logic [N-1:0]    credit_return;
   logic            busy;
   logic            credit_err;

   always #5 clk = ~clk;

   first_edge_rd_arbiter #(
      .REQ_NUM(N), .AWIDTH(AW), .DWIDTH(DW), .RD_LATENCY(2), .CREDIT_MAX(CM)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
      .bram_en(bram_en), .bram_addr(bram_addr), .bram_data(bram_data),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .credit_return(credit_return), .busy(busy), .credit_err(credit_err)
   );

   function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
      return 32'hC0DE_0000 ^ {a, 6'h2A, a, 6'h15};
   endfunction

   logic [DW-1:0] rom_s1, rom_s2;
   always @(posedge clk) begin
      rom_s1 <= rom_f(bram_addr);
      rom_s2 <= rom_s1;
   end
   assign bram_data = rom_s2;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference model: credits as integers, outstanding reads as a queue with due cycles.
   typedef struct {
      int            id;
      logic [AW-1:0] addr;
      int            due;
   } pend_t;

   int            m_cred [N];
   int            m_ptr;
   bit            m_err;
   bit            m_en;
   logic [AW-1:0] m_addr;
   pend_t         m_q [$];
   int            cyc;

   task automatic model_reset();
      for (int i = 0; i < N; i++) m_cred[i] = CM;
      m_ptr  = 0;
      m_err  = 1'b0;
      m_en   = 1'b0;
      m_addr = '0;
      m_q.delete();
   endtask

   // Drive one cycle of inputs, compare every output with the model, then advance the model.
   task automatic step(input logic r, input logic [N-1:0] v, input logic [N*AW-1:0] a,
                       input logic [N-1:0] cr);
      int            g;
      int            idx;
      logic [N-1:0]  er;
      logic [N-1:0]  ersp;
      logic [DW-1:0] edat;
      pend_t         p;
      @(posedge clk);
      #1;
      rst           = r;
      req_valid     = v;
      req_addr      = a;
      credit_return = cr;
      @(negedge clk);
      g = -1;
      if (r) begin
         for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (g < 0 && v[idx] && m_cred[idx] > 0) g = idx;
         end
      end
      er   = (g >= 0) ? (4'b0001 << g) : 4'b0000;
      ersp = '0;
      edat = '0;
      if (r && m_q.size() > 0 && m_q[0].due == cyc) begin
         ersp = 4'b0001 << m_q[0].id;
         edat = rom_f(m_q[0].addr);
      end
      chk("req_ready", 64'(req_ready), 64'(er));
      chk("bram_en", 64'(bram_en), 64'(m_en));
      chk("bram_addr", 64'(bram_addr), 64'(m_addr));
      chk("rsp_valid", 64'(rsp_valid), 64'(ersp));
      if (ersp != '0) chk("rsp_data", 64'(rsp_data), 64'(edat));
      chk("busy", 64'(busy), 64'(m_q.size() != 0));
      chk("credit_err", 64'(credit_err), 64'(m_err));
      if (!r) begin
         model_reset();
      end else begin
         if (m_q.size() > 0 && m_q[0].due == cyc) void'(m_q.pop_front());
         for (int i = 0; i < N; i++) begin
            if (g == i && !cr[i]) m_cred[i]--;
            else if (g != i && cr[i]) begin
               if (m_cred[i] == CM) m_err = 1'b1;
               else m_cred[i]++;
            end
         end
         if (g >= 0) begin
            p.id   = g;
            p.addr = a[g*AW +: AW];
            p.due  = cyc + LAT;
            m_q.push_back(p);
            m_en   = 1'b1;
            m_addr = a[g*AW +: AW];
            m_ptr  = (g + 1) % N;
         end else begin
            m_en = 1'b0;
         end
      end
      cyc++;
   endtask

   typedef struct {
      logic          r;
      logic [N-1:0]  v;
      logic [N-1:0]  cr;
      logic [N-1:0]  er;
      logic          en;
      logic [AW-1:0] ad;
      logic [N-1:0]  rsp;
      logic          busy;
      logic          err;
   } vec_t;

   localparam logic [N*AW-1:0] TA = {10'h043, 10'h032, 10'h021, 10'h010};

   vec_t tbl [20];
   int   ngr;

   initial begin
      rst           = 1'b0;
      req_valid     = '0;
      req_addr      = '0;
      credit_return = '0;
      cyc           = 0;
      model_reset();

      //            r     v        cr       ready    en    addr     rsp      busy  err
      tbl[0]  = '{1'b1, 4'b0001, 4'b0000, 4'b0001, 1'b0, 10'h000, 4'b0000, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b1, 10'h010, 4'b0000, 1'b1, 1'b0};
      tbl[2]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 10'h010, 4'b0000, 1'b1, 1'b0};
      tbl[3]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 10'h010, 4'b0001, 1'b1, 1'b0};
      tbl[4]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 10'h010, 4'b0000, 1'b0, 1'b0};
      // requester 1: grant and credit return together, no error
      tbl[5]  = '{1'b1, 4'b0010, 4'b0010, 4'b0010, 1'b0, 10'h010, 4'b0000, 1'b0, 1'b0};
      // requester 3 already full: return flags the sticky error
      tbl[6]  = '{1'b1, 4'b0000, 4'b1000, 4'b0000, 1'b1, 10'h021, 4'b0000, 1'b1, 1'b0};
      tbl[7]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 10'h021, 4'b0000, 1'b1, 1'b1};
      tbl[8]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 10'h021, 4'b0010, 1'b1, 1'b1};
      tbl[9]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 10'h021, 4'b0000, 1'b0, 1'b1};
      // two grants, then reset: their responses must never appear
      tbl[10] = '{1'b1, 4'b0100, 4'b0000, 4'b0100, 1'b0, 10'h021, 4'b0000, 1'b0, 1'b1};
      tbl[11] = '{1'b1, 4'b1000, 4'b0000, 4'b1000, 1'b1, 10'h032, 4'b0000, 1'b1, 1'b1};
      tbl[12] = '{1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b1, 10'h043, 4'b0000, 1'b1, 1'b1};
      tbl[13] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 10'h000, 4'b0000, 1'b0, 1'b0};
      // pointer back at 0 after reset
      tbl[14] = '{1'b1, 4'b1111, 4'b0000, 4'b0001, 1'b0, 10'h000, 4'b0000, 1'b0, 1'b0};
      tbl[15] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b1, 10'h010, 4'b0000, 1'b1, 1'b0};
      tbl[16] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 10'h010, 4'b0000, 1'b1, 1'b0};
      tbl[17] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 10'h010, 4'b0001, 1'b1, 1'b0};
      tbl[18] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 10'h010, 4'b0000, 1'b0, 1'b0};
      tbl[19] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 10'h010, 4'b0000, 1'b0, 1'b0};

      for (int i = 0; i < 3; i++) step(1'b0, '0, '0, '0);

      for (int t = 0; t < 20; t++) begin
         step(tbl[t].r, tbl[t].v, TA, tbl[t].cr);
         chk($sformatf("tbl%0d_ready", t), 64'(req_ready), 64'(tbl[t].er));
         chk($sformatf("tbl%0d_en", t), 64'(bram_en), 64'(tbl[t].en));
         chk($sformatf("tbl%0d_addr", t), 64'(bram_addr), 64'(tbl[t].ad));
         chk($sformatf("tbl%0d_rsp", t), 64'(rsp_valid), 64'(tbl[t].rsp));
         // bram_addr holds the completing read's address in every response row
         if (tbl[t].rsp != '0) chk($sformatf("tbl%0d_data", t), 64'(rsp_data), 64'(rom_f(tbl[t].ad)));
         chk($sformatf("tbl%0d_busy", t), 64'(busy), 64'(tbl[t].busy));
         chk($sformatf("tbl%0d_err", t), 64'(credit_err), 64'(tbl[t].err));
      end

      // All requesters valid, no returns: 0,1,2,3,... until each has used 8 credits.
      ngr = 0;
      for (int k = 0; k < 40; k++) begin
         step(1'b1, 4'b1111, TA, 4'b0000);
         chk($sformatf("exh%0d_ready", k), 64'(req_ready),
             64'((k < 4 * CM) ? (4'b0001 << (k % N)) : 4'b0000));
         if (req_ready != '0) ngr++;
      end
      chk("exh_total_grants", 64'(ngr), 64'(4 * CM));

      // Requester 2 at zero credit: one return buys exactly one grant.
      step(1'b1, 4'b1111, TA, 4'b0100);
      chk("refill_same_cycle", 64'(req_ready), 64'(4'b0000));
      step(1'b1, 4'b1111, TA, 4'b0000);
      chk("refill_grant", 64'(req_ready), 64'(4'b0100));
      step(1'b1, 4'b1111, TA, 4'b0000);
      chk("refill_empty_again", 64'(req_ready), 64'(4'b0000));
      for (int k = 0; k < 4; k++) step(1'b1, 4'b0000, TA, 4'b0000);

      // Randomized traffic against the model, with occasional resets.
      for (int k = 0; k < 600; k++) begin
         logic [N*AW-1:0] ra;
         ra = {8'($urandom), 32'($urandom)};
         step(($urandom_range(0, 99) != 0), 4'($urandom), ra, 4'($urandom) & 4'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
